xor_nn_stream_loader: RTL

Upstream front end for the xor_nn inference core. It parses a byte stream (valid/ready) into two kinds of frame. LOAD frames are turned into per-weight write strobes for the core's w1/w2 arrays. RUN frames are turned into a single-cycle in_en/in_data pulse, followed by a settle wait so the core's registered output is stable before the next frame is accepted.

---
 rtl/xor_nn_pkg.sv | 16 +
 rtl/xor_nn_weight_addr_gen.sv | 55 +++++
 rtl/xor_nn_stream_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/xor_nn_pkg.sv
// Shared constants and state encoding for the xor_nn core and its front-end stages.
package xor_nn_pkg;

  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN  = 8'h3C;
  localparam int         W1_COUNT = 6;
  localparam int         W2_COUNT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN_ARG = 2'd2,
    SETTLE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/xor_nn_weight_addr_gen.sv
// Walks the w1 then w2 weight arrays in row-major order using nested row/column
// counters; done marks the final w2 element.
module xor_nn_weight_addr_gen import xor_nn_pkg::*; #(
  parameter int INPUT_VECTOR_SIZE   = 2,
  parameter int HIDDEN_LAYER_SIZE   = 2,
  parameter int OUTPUT_VECTOR_SIZE  = 1,
  parameter int BIAS_SIZE           = 1,
  parameter int CLOG2_MAX_WEIGHTS_N = 2,
  parameter int CLOG2_MAX_WEIGHTS_M = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           step,
  output logic                           layer,
  output logic [CLOG2_MAX_WEIGHTS_N-1:0] n_address,
  output logic [CLOG2_MAX_WEIGHTS_M-1:0] m_address,
  output logic                           done
);

  localparam int NW = CLOG2_MAX_WEIGHTS_N;
  localparam int MW = CLOG2_MAX_WEIGHTS_M;
  localparam logic [NW-1:0] W1_ROW_LAST = NW'(INPUT_VECTOR_SIZE + BIAS_SIZE - 1);
  localparam logic [MW-1:0] W1_COL_LAST = MW'(HIDDEN_LAYER_SIZE - 1);
  localparam logic [NW-1:0] W2_ROW_LAST = NW'(HIDDEN_LAYER_SIZE + BIAS_SIZE - 1);
  localparam logic [MW-1:0] W2_COL_LAST = MW'(OUTPUT_VECTOR_SIZE - 1);

  logic [NW-1:0] row_last;
  logic [MW-1:0] col_last;

  assign row_last = layer ? W2_ROW_LAST : W1_ROW_LAST;
  assign col_last = layer ? W2_COL_LAST : W1_COL_LAST;
  assign done     = layer && (n_address == W2_ROW_LAST) && (m_address == W2_COL_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      layer     <= 1'b0;
      n_address <= '0;
      m_address <= '0;
    end else if (step) begin
      if (m_address == col_last) begin
        m_address <= '0;
        if (n_address == row_last) begin
          n_address <= '0;
          layer     <= ~layer;
        end else begin
          n_address <= n_address + 1'b1;
        end
      end else begin
        m_address <= m_address + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_nn_stream_loader.sv
// Byte-stream front end for xor_nn: LOAD frames become weight write strobes, RUN
// frames become an in_en pulse plus settle stall. XOR_NN_LOADER_CHECKSUM_EN adds a LOAD checksum byte.
//
// state   | meaning
// IDLE    | waiting for a command byte
// LOAD    | receiving weight bytes (and checksum byte when enabled)
// RUN_ARG | waiting for the input-vector byte of a RUN frame
// SETTLE  | stalling the stream while the core output settles
module xor_nn_stream_loader import xor_nn_pkg::*; #(
  parameter int                 BITS_PER_WORD       = 8,
  parameter int                 INPUT_VECTOR_SIZE   = 2,
  parameter int                 HIDDEN_LAYER_SIZE   = 2,
  parameter int                 OUTPUT_VECTOR_SIZE  = 1,
  parameter int                 BIAS_SIZE           = 1,
  parameter int                 CLOG2_MAX_WEIGHTS_N = 2,
  parameter int                 CLOG2_MAX_WEIGHTS_M = 2,
  parameter int                 SETTLE_CYCLES       = 2,
  parameter logic [BITS_PER_WORD-1:0] CMD_LOAD      = xor_nn_pkg::CMD_LOAD,
  parameter logic [BITS_PER_WORD-1:0] CMD_RUN       = xor_nn_pkg::CMD_RUN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [BITS_PER_WORD-1:0]       s_data,
  output logic                           weights_en,
  output logic                           weights_layer_address,
  output logic [CLOG2_MAX_WEIGHTS_N-1:0] weights_n_address,
  output logic [CLOG2_MAX_WEIGHTS_M-1:0] weights_m_address,
  output logic [BITS_PER_WORD-1:0]       weights_data,
  output logic                           in_en,
  output logic [INPUT_VECTOR_SIZE-1:0]   in_data,
  output logic                           weights_loaded,
  output logic                           err
);

  loader_state_t state, state_n;
  logic [3:0] settle_cnt, settle_n;
  logic       loaded_n, err_n, wen_n, ien_n, accept;
  logic       gen_clear, gen_step, gen_layer, gen_last;
  logic [CLOG2_MAX_WEIGHTS_N-1:0] gen_n;
  logic [CLOG2_MAX_WEIGHTS_M-1:0] gen_m;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
  logic [BITS_PER_WORD-1:0] csum, csum_n;
  logic                     chk_phase, chk_n;
`endif

  assign s_ready = (state != SETTLE);
  assign accept  = s_valid && s_ready;

  xor_nn_weight_addr_gen #(
    .INPUT_VECTOR_SIZE  (INPUT_VECTOR_SIZE),
    .HIDDEN_LAYER_SIZE  (HIDDEN_LAYER_SIZE),
    .OUTPUT_VECTOR_SIZE (OUTPUT_VECTOR_SIZE),
    .BIAS_SIZE          (BIAS_SIZE),
    .CLOG2_MAX_WEIGHTS_N(CLOG2_MAX_WEIGHTS_N),
    .CLOG2_MAX_WEIGHTS_M(CLOG2_MAX_WEIGHTS_M)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (gen_clear),
    .step     (gen_step),
    .layer    (gen_layer),
    .n_address(gen_n),
    .m_address(gen_m),
    .done     (gen_last)
  );

  always_comb begin
    state_n   = state;
    settle_n  = settle_cnt;
    loaded_n  = weights_loaded;
    err_n     = err;
    wen_n     = 1'b0;
    ien_n     = 1'b0;
    gen_clear = 1'b0;
    gen_step  = 1'b0;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
    csum_n    = csum;
    chk_n     = chk_phase;
`endif
    case (state)
      IDLE: if (accept) begin
        if (s_data == CMD_LOAD) begin
          state_n   = LOAD;
          loaded_n  = 1'b0;
          gen_clear = 1'b1;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
          csum_n    = '0;
          chk_n     = 1'b0;
`endif
        end else if (s_data == CMD_RUN) begin
          state_n = RUN_ARG;
        end else begin
          err_n = 1'b1;
        end
      end
      LOAD: if (accept) begin
`ifdef XOR_NN_LOADER_CHECKSUM_EN
        if (chk_phase) begin
          state_n = IDLE;
          if (s_data == csum) loaded_n = 1'b1;
          else                err_n    = 1'b1;
        end else begin
          wen_n    = 1'b1;
          gen_step = 1'b1;
          csum_n   = csum + s_data;
          chk_n    = gen_last;
        end
`else
        wen_n    = 1'b1;
        gen_step = 1'b1;
        if (gen_last) begin
          loaded_n = 1'b1;
          state_n  = IDLE;
        end
`endif
      end
      RUN_ARG: if (accept) begin
        if (weights_loaded) begin
          ien_n    = 1'b1;
          settle_n = 4'(SETTLE_CYCLES);
          state_n  = SETTLE;
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      SETTLE: begin
        // The in_en cycle itself is the first stalled cycle.
        settle_n = settle_cnt - 4'd1;
        if (settle_n == 4'd0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      settle_cnt            <= '0;
      weights_en            <= 1'b0;
      weights_layer_address <= 1'b0;
      weights_n_address     <= '0;
      weights_m_address     <= '0;
      weights_data          <= '0;
      in_en                 <= 1'b0;
      in_data               <= '0;
      weights_loaded        <= 1'b0;
      err                   <= 1'b0;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
      csum                  <= '0;
      chk_phase             <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      settle_cnt     <= settle_n;
      weights_en     <= wen_n;
      in_en          <= ien_n;
      weights_loaded <= loaded_n;
      err            <= err_n;
`ifdef XOR_NN_LOADER_CHECKSUM_EN
      csum           <= csum_n;
      chk_phase      <= chk_n;
`endif
      if (wen_n) begin
        weights_layer_address <= gen_layer;
        weights_n_address     <= gen_n;
        weights_m_address     <= gen_m;
        weights_data          <= s_data;
      end
      if (ien_n) in_data <= s_data[INPUT_VECTOR_SIZE-1:0];
    end
  end

endmodule
